// File: rtl/mmu_line_ctrl.sv
// Memory-side line controller below the L1 data cache: splits 256-bit line requests
// (or single-word MMIO requests) into 32-bit req/ack beats and reassembles read lines.
module mmu_line_ctrl #(
    parameter logic [15:0] MMIO_HI = 16'hFFFF,
    parameter int unsigned BEATS   = 8
) (
    input  logic         sys_clk,
    input  logic         rst_n,
    input  logic         req_read,
    input  logic         req_write,
    input  logic [31:0]  req_addr,
    input  logic [255:0] req_wdata,
    output logic         read_done,
    output logic         write_done,
    output logic [255:0] read_data,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [31:0]  mem_wdata,
    input  logic         mem_ack,
    input  logic [31:0]  mem_rdata
);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWr,
        StDone,
        StGap
    } state_e;

    localparam logic [2:0] LastBeat = 3'(BEATS - 1);

    state_e                   state_q, state_d;
    logic [2:0]               beat_q, beat_d;
    logic [31:0]              addr_q, addr_d;
    logic                     mmio_q, mmio_d;
    logic                     wr_q, wr_d;
    logic [BEATS-1:0][31:0]   line_q, line_d;
    logic [255:0]             rdata_q, rdata_d;

    logic busy;
    logic last_beat;

    assign busy      = (state_q == StRd) || (state_q == StWr);
    assign last_beat = mmio_q ? (beat_q == 3'd0) : (beat_q == LastBeat);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            beat_q  <= 3'd0;
            addr_q  <= 32'd0;
            mmio_q  <= 1'b0;
            wr_q    <= 1'b0;
            line_q  <= '0;
            rdata_q <= 256'd0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            mmio_q  <= mmio_d;
            wr_q    <= wr_d;
            line_q  <= line_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        mmio_d  = mmio_q;
        wr_d    = wr_q;
        line_d  = line_q;
        rdata_d = rdata_q;

        unique case (state_q)
            StIdle: begin
                // Write wins a tie; the cache re-presents the read after write_done.
                if (req_write) begin
                    addr_d  = req_addr;
                    line_d  = req_wdata;
                    mmio_d  = (req_addr[31:16] == MMIO_HI);
                    wr_d    = 1'b1;
                    beat_d  = 3'd0;
                    state_d = StWr;
                end else if (req_read) begin
                    addr_d  = req_addr;
                    mmio_d  = (req_addr[31:16] == MMIO_HI);
                    wr_d    = 1'b0;
                    beat_d  = 3'd0;
                    state_d = StRd;
                end
            end
            StRd, StWr: begin
                if (mem_ack) begin
                    if (state_q == StRd) begin
                        line_d[beat_q] = mem_rdata;
                    end
                    if (last_beat) begin
                        beat_d  = 3'd0;
                        state_d = StDone;
                        // read_data only changes once a whole read has landed.
                        if (state_q == StRd) begin
                            rdata_d = mmio_q ? {224'd0, mem_rdata} : 256'(line_d);
                        end
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end
            end
            StDone:  state_d = StGap;
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign mem_req    = busy;
    assign mem_we     = (state_q == StWr);
    assign mem_addr   = !busy  ? 32'd0 :
                        mmio_q ? addr_q : {addr_q[31:5], beat_q, 2'b00};
    assign mem_wdata  = (state_q == StWr) ? line_q[beat_q] : 32'd0;
    assign read_done  = (state_q == StDone) && !wr_q;
    assign write_done = (state_q == StDone) && wr_q;
    assign read_data  = rdata_q;

endmodule

// File: tb/tb_mmu_line_ctrl.sv
// Scoreboard bench for mmu_line_ctrl: stimulus queues expected beats and done events,
// an independent monitor pops and compares them as the DUT presents them.
module tb_mmu_line_ctrl;

    logic         sys_clk = 1'b0;
    logic         rst_n;
    logic         req_read;
    logic         req_write;
    logic [31:0]  req_addr;
    logic [255:0] req_wdata;
    logic         read_done;
    logic         write_done;
    logic [255:0] read_data;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_ack;
    logic [31:0]  mem_rdata;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic         is_wr;
        logic [255:0] data;
    } done_t;

    beat_t exp_beats[$];
    done_t exp_dones[$];

    int n_checks   = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int beats_seen = 0;
    int wait_cycles;
    bit mmio_data;

    mmu_line_ctrl dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .req_read   (req_read),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .read_done  (read_done),
        .write_done (write_done),
        .read_data  (read_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 sys_clk = ~sys_clk;

    initial forever begin
        @(posedge sys_clk);
        cyc++;
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    function automatic logic [255:0] addr_line(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = base + 32'(4 * i);
        return l;
    endfunction

    task automatic push_line(input logic [31:0] base, input bit we, input logic [255:0] wl);
        beat_t b;
        for (int i = 0; i < 8; i++) begin
            b.addr  = base + 32'(4 * i);
            b.we    = we;
            b.wdata = wl[32*i +: 32];
            exp_beats.push_back(b);
        end
    endtask

    task automatic push_done(input bit is_wr, input logic [255:0] data);
        done_t d;
        d.is_wr = is_wr;
        d.data  = data;
        exp_dones.push_back(d);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
        #3;
    endtask

    // Waits for the wanted done pulse, then drops that request as the cache would.
    task automatic wait_done(input bit want_wr, output int lat);
        int c0;
        bit found;
        c0    = cyc;
        found = 1'b0;
        lat   = -1;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge sys_clk);
            #3;
            if (want_wr ? write_done : read_done) begin
                found = 1'b1;
                lat   = cyc - c0;
            end
        end
        check(want_wr ? "write_done_seen" : "read_done_seen", found, 1);
        if (want_wr) req_write = 1'b0;
        else         req_read  = 1'b0;
    endtask

    // Memory responder: ack after wait_cycles idle cycles, data = address or MMIO constant.
    initial begin
        int wcnt;
        wcnt      = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge sys_clk);
            if (mem_ack) wcnt = 0;
            if (mem_req && rst_n) begin
                if (wcnt >= wait_cycles) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mmio_data ? 32'h5A : mem_addr;
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end
        end
    end

    // Monitor
    initial begin
        beat_t b;
        done_t d;
        forever begin
            @(negedge sys_clk);
            #2;
            if (rst_n) begin
                if (mem_req && mem_ack) begin
                    check("beat_expected", exp_beats.size() > 0, 1);
                    if (exp_beats.size() > 0) begin
                        b = exp_beats.pop_front();
                        check("beat_addr", mem_addr, b.addr);
                        check("beat_we", mem_we, b.we);
                        if (b.we) check("beat_wdata", mem_wdata, b.wdata);
                        beats_seen++;
                    end
                end
                if (read_done || write_done) begin
                    check("done_exclusive", read_done && write_done, 0);
                    check("done_expected", exp_dones.size() > 0, 1);
                    if (exp_dones.size() > 0) begin
                        d = exp_dones.pop_front();
                        check("done_kind", write_done, d.is_wr);
                        if (!d.is_wr) check("read_data", read_data, d.data);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int n;
        int base;
        logic [255:0] wl;

        rst_n       = 1'b0;
        req_read    = 1'b0;
        req_write   = 1'b0;
        req_addr    = 32'd0;
        req_wdata   = 256'd0;
        wait_cycles = 0;
        mmio_data   = 1'b0;

        idle(3);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_read_data", read_data, 0);
        check("rst_read_done", read_done, 0);
        check("rst_write_done", write_done, 0);
        rst_n = 1'b1;
        idle(2);

        // 1: cached read, zero-wait memory
        push_line(32'h1220, 1'b0, 256'd0);
        push_done(1'b0, addr_line(32'h1220));
        req_addr = 32'h0000_1234;
        req_read = 1'b1;
        wait_done(1'b0, lat);
        check("t1_read_latency", lat, 9);
        idle(3);

        // 2: cached write, two wait cycles per beat
        for (int i = 0; i < 8; i++) wl[32*i +: 32] = 32'hA0 + 32'(i);
        wait_cycles = 2;
        push_line(32'h8040, 1'b1, wl);
        push_done(1'b1, 256'd0);
        req_addr  = 32'h0000_8040;
        req_wdata = wl;
        req_write = 1'b1;
        wait_done(1'b1, lat);
        check("t2_write_latency", lat, 25);
        idle(3);
        check("t2_read_data_hold", read_data, addr_line(32'h1220));

        // 3: MMIO read
        wait_cycles = 0;
        mmio_data   = 1'b1;
        begin
            beat_t b;
            b.addr  = 32'hFFFF_0010;
            b.we    = 1'b0;
            b.wdata = 32'd0;
            exp_beats.push_back(b);
        end
        push_done(1'b0, 256'h5A);
        req_addr = 32'hFFFF_0010;
        req_read = 1'b1;
        wait_done(1'b0, lat);
        check("t3_mmio_latency", lat, 2);
        mmio_data = 1'b0;
        idle(3);

        // 4: write-back then refill; the refill must wait out the GAP cycle
        for (int i = 0; i < 8; i++) wl[32*i +: 32] = 32'h1000_0000 + 32'(i);
        push_line(32'h100, 1'b1, wl);
        push_done(1'b1, 256'd0);
        push_line(32'h2100, 1'b0, 256'd0);
        push_done(1'b0, addr_line(32'h2100));
        req_addr  = 32'h0000_0100;
        req_wdata = wl;
        req_write = 1'b1;
        wait_done(1'b1, lat);
        req_addr = 32'h0000_2100;
        req_read = 1'b1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge sys_clk);
            #3;
            n++;
            if (mem_req) break;
        end
        check("t4_gap_cycles", n, 3);
        wait_done(1'b0, lat);
        idle(3);

        // 5: read and write together, write served first
        for (int i = 0; i < 8; i++) wl[32*i +: 32] = 32'hC0DE_0000 + 32'(i);
        push_line(32'h3000, 1'b1, wl);
        push_done(1'b1, 256'd0);
        push_line(32'h3000, 1'b0, 256'd0);
        push_done(1'b0, addr_line(32'h3000));
        req_addr  = 32'h0000_3000;
        req_wdata = wl;
        req_read  = 1'b1;
        req_write = 1'b1;
        wait_done(1'b1, lat);
        wait_done(1'b0, lat);
        idle(3);

        // 6: reset in the middle of a read
        push_line(32'h4000, 1'b0, 256'd0);
        req_addr = 32'h0000_4000;
        req_read = 1'b1;
        base = beats_seen;
        for (int k = 0; k < 50; k++) begin
            @(negedge sys_clk);
            #3;
            if (beats_seen == base + 4) break;
        end
        check("t6_beats_before_reset", beats_seen - base, 4);
        @(posedge sys_clk);
        #2;
        rst_n    = 1'b0;
        req_read = 1'b0;
        exp_beats.delete();
        exp_dones.delete();
        #1;
        check("t6_mem_req_in_reset", mem_req, 0);
        check("t6_mem_addr_in_reset", mem_addr, 0);
        idle(2);
        check("t6_read_data_in_reset", read_data, 0);
        check("t6_read_done_in_reset", read_done, 0);
        rst_n = 1'b1;
        idle(1);
        push_line(32'h4000, 1'b0, 256'd0);
        push_done(1'b0, addr_line(32'h4000));
        req_read = 1'b1;
        wait_done(1'b0, lat);
        check("t6_restart_latency", lat, 9);

        idle(5);
        check("beats_drained", exp_beats.size(), 0);
        check("dones_drained", exp_dones.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
